// File: rtl/alu_op_sequencer.sv
// Command sequencer for alu_regfile: issues one instruction at a time, captures the
// ALU result, writes it back, and returns it through a valid/ready result port.
module alu_op_sequencer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 9,
    parameter int OP_W   = 3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic              In_kind,
    input  logic [OP_W-1:0]   In_opcode,
    input  logic              In_use_flag,
    input  logic              In_cin,
    input  logic [ADDR_W-1:0] In_rs1,
    input  logic [ADDR_W-1:0] In_rs2,
    input  logic [ADDR_W-1:0] In_rd,
    input  logic              In_wb,
    input  logic [DATA_W-1:0] In_imm,
    output logic [ADDR_W-1:0] Read_Addr_1,
    output logic [ADDR_W-1:0] Read_Addr_2,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic              Write_enable,
    output logic [DATA_W-1:0] Write_data,
    output logic              Carry_In,
    output logic [OP_W-1:0]   Opcode,
    input  logic [OUT_W-1:0]  ALU_Out,
    output logic              Res_valid,
    input  logic              Res_ready,
    output logic [OUT_W-1:0]  Res_data,
    output logic              Carry_flag
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state;
    logic             wb_pending;
    logic [OUT_W-1:0] result;

    assign In_ready  = (state == S_IDLE);
    assign Res_valid = (state == S_RESP);
    assign Res_data  = result;

    // NOTE: Write_enable is a flop cleared by the async reset, so a reset during WB
    // removes the write strobe at once instead of waiting for the next clock edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            wb_pending   <= 1'b0;
            result       <= '0;
            Read_Addr_1  <= '0;
            Read_Addr_2  <= '0;
            Write_Addr   <= '0;
            Write_enable <= 1'b0;
            Write_data   <= '0;
            Carry_In     <= 1'b0;
            Opcode       <= '0;
            Carry_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (In_valid) begin
                        Write_Addr <= In_rd;
                        wb_pending <= In_wb;
                        if (In_kind) begin
                            // Load-immediate skips the ALU entirely and writes unconditionally.
                            result       <= {{(OUT_W-DATA_W){1'b0}}, In_imm};
                            Write_data   <= In_imm;
                            Write_enable <= 1'b1;
                            state        <= S_WB;
                        end else begin
                            Read_Addr_1 <= In_rs1;
                            Read_Addr_2 <= In_rs2;
                            Opcode      <= In_opcode;
                            Carry_In    <= In_use_flag ? Carry_flag : In_cin;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // Capture happens before the write-back edge, so rd == rs1/rs2 reads the old value.
                    result       <= ALU_Out;
                    Write_data   <= ALU_Out[DATA_W-1:0];
                    Carry_flag   <= ALU_Out[DATA_W];
                    Write_enable <= wb_pending;
                    state        <= S_WB;
                end
                S_WB: begin
                    Write_enable <= 1'b0;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (Res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    Write_enable <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a small register-file/ALU stand-in plus an array-based
// reference model of the instruction stream, with directed and randomized scenarios.
module tb_alu_op_sequencer;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       In_valid = 1'b0;
    logic       In_ready;
    logic       In_kind = 1'b0;
    logic [2:0] In_opcode = '0;
    logic       In_use_flag = 1'b0;
    logic       In_cin = 1'b0;
    logic [2:0] In_rs1 = '0, In_rs2 = '0, In_rd = '0;
    logic       In_wb = 1'b0;
    logic [7:0] In_imm = '0;
    logic [2:0] Read_Addr_1, Read_Addr_2, Write_Addr;
    logic       Write_enable;
    logic [7:0] Write_data;
    logic       Carry_In;
    logic [2:0] Opcode;
    logic [8:0] ALU_Out;
    logic       Res_valid;
    logic       Res_ready = 1'b0;
    logic [8:0] Res_data;
    logic       Carry_flag;

    int n_checks = 0;
    int n_fail = 0;

    alu_op_sequencer #(.ADDR_W(3), .DATA_W(8), .OUT_W(9), .OP_W(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .In_valid(In_valid), .In_ready(In_ready), .In_kind(In_kind), .In_opcode(In_opcode),
        .In_use_flag(In_use_flag), .In_cin(In_cin), .In_rs1(In_rs1), .In_rs2(In_rs2),
        .In_rd(In_rd), .In_wb(In_wb), .In_imm(In_imm),
        .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2), .Write_Addr(Write_Addr),
        .Write_enable(Write_enable), .Write_data(Write_data), .Carry_In(Carry_In),
        .Opcode(Opcode), .ALU_Out(ALU_Out), .Res_valid(Res_valid), .Res_ready(Res_ready),
        .Res_data(Res_data), .Carry_flag(Carry_flag)
    );

    always #5 Clock = ~Clock;

    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b} + {8'd0, c};
            OP_SUB:  return {1'b0, a} + {1'b0, ~b} + {8'd0, c};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    // Stand-in for alu_regfile: combinational ALU over two read ports, clocked write port.
    logic [7:0] rf [8] = '{default: 8'h00};
    always_comb ALU_Out = alu_fn(Opcode, rf[Read_Addr_1], rf[Read_Addr_2], Carry_In);
    always @(posedge Clock) if (Write_enable) rf[Write_Addr] <= Write_data;

    // Write monitor: counts cycles with the write strobe high and remembers the last one.
    int         wr_total = 0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    always @(negedge Clock) begin
        if (Write_enable) begin
            wr_total = wr_total + 1;
            wr_addr  = Write_Addr;
            wr_data  = Write_data;
        end
    end

    // Reference model: architectural register contents and the sticky carry flag.
    logic [7:0] m_rf [8] = '{default: 8'h00};
    logic       m_flag = 1'b0;

    task automatic model_exec(input bit kind, input logic [2:0] op, input bit uf, input bit cin,
                              input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                              input bit wb, input logic [7:0] imm,
                              output logic [8:0] e_res, output int e_lat, output int e_nwr,
                              output logic e_ci);
        logic [8:0] r;
        if (kind) begin
            e_res = {1'b0, imm};
            e_lat = 2;
            e_nwr = 1;
            e_ci  = 1'b0;
            m_rf[rd] = imm;
        end else begin
            e_ci  = uf ? m_flag : cin;
            r     = alu_fn(op, m_rf[rs1], m_rf[rs2], e_ci);
            e_res = r;
            e_lat = 4;
            e_nwr = wb ? 1 : 0;
            m_flag = r[8];
            if (wb) m_rf[rd] = r[7:0];
        end
    endtask

    task automatic do_instr(input bit kind, input logic [2:0] op, input bit uf, input bit cin,
                            input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                            input bit wb, input logic [7:0] imm, input int stall,
                            output int lat, output logic [8:0] res, output int nwr,
                            output logic [2:0] wa, output logic [7:0] wd, output logic ci,
                            output bit stable);
        int w0;
        @(negedge Clock);
        In_kind = kind; In_opcode = op; In_use_flag = uf; In_cin = cin;
        In_rs1 = rs1; In_rs2 = rs2; In_rd = rd; In_wb = wb; In_imm = imm;
        In_valid = 1'b1;
        w0 = wr_total;
        @(posedge Clock);
        #1;
        In_valid = 1'b0;
        // Scramble the request fields while busy; the sequencer must ignore them.
        In_kind = 1'($urandom); In_opcode = 3'($urandom); In_use_flag = 1'($urandom);
        In_cin = 1'($urandom); In_rs1 = 3'($urandom); In_rs2 = 3'($urandom);
        In_rd = 3'($urandom); In_wb = 1'($urandom); In_imm = 8'($urandom);
        ci  = Carry_In;
        lat = 1;
        while (!Res_valid && lat < 20) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        res    = Res_data;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge Clock);
            #1;
            if (Res_data !== res || Res_valid !== 1'b1 || In_ready !== 1'b0) stable = 1'b0;
        end
        Res_ready = 1'b1;
        @(posedge Clock);
        #1;
        Res_ready = 1'b0;
        nwr = wr_total - w0;
        wa  = wr_addr;
        wd  = wr_data;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        n_checks++; if (In_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", In_ready); end
        n_checks++; if (Res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b exp 0", Res_valid); end
        n_checks++; if (Write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", Write_enable); end
        n_checks++; if (Carry_flag !== 1'b0) begin n_fail++; $display("FAIL rst_flag: got %b exp 0", Carry_flag); end
        n_checks++; if ({Read_Addr_1, Read_Addr_2, Write_Addr, Opcode} !== 12'h000) begin n_fail++; $display("FAIL rst_addr_op: got %h exp 000", {Read_Addr_1, Read_Addr_2, Write_Addr, Opcode}); end
        n_checks++; if ({Write_data, Res_data, Carry_In} !== 18'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", {Write_data, Res_data, Carry_In}); end
        Reset_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_directed();
        int lat, nwr, e_lat, e_nwr;
        logic [8:0] res, e_res;
        logic [2:0] wa;
        logic [7:0] wd;
        logic ci, e_ci;
        bit st;
        // LI r1=0x0F, LI r2=0xF1
        model_exec(1, 0, 0, 0, 0, 0, 1, 0, 8'h0F, e_res, e_lat, e_nwr, e_ci);
        do_instr(1, 0, 0, 0, 0, 0, 1, 0, 8'h0F, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h00F || lat !== 2) begin n_fail++; $display("FAIL li1: res %h lat %0d exp 00f lat 2", res, lat); end
        n_checks++; if (nwr !== 1 || wa !== 3'd1 || wd !== 8'h0F) begin n_fail++; $display("FAIL li1_wr: n %0d a %0d d %h exp 1/1/0f", nwr, wa, wd); end
        model_exec(1, 0, 0, 0, 0, 0, 2, 0, 8'hF1, e_res, e_lat, e_nwr, e_ci);
        do_instr(1, 0, 0, 0, 0, 0, 2, 0, 8'hF1, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h0F1 || nwr !== 1 || wa !== 3'd2 || wd !== 8'hF1) begin n_fail++; $display("FAIL li2: res %h n %0d a %0d d %h exp 0f1/1/2/f1", res, nwr, wa, wd); end
        // ADD r3 = r1 + r2 with explicit cin=0
        model_exec(0, OP_ADD, 0, 0, 1, 2, 3, 1, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_ADD, 0, 0, 1, 2, 3, 1, 0, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h100 || lat !== 4) begin n_fail++; $display("FAIL add_carry: res %h lat %0d exp 100 lat 4", res, lat); end
        n_checks++; if (Carry_flag !== 1'b1) begin n_fail++; $display("FAIL add_flag: got %b exp 1", Carry_flag); end
        n_checks++; if (nwr !== 1 || wa !== 3'd3 || wd !== 8'h00) begin n_fail++; $display("FAIL add_wr: n %0d a %0d d %h exp 1/3/00", nwr, wa, wd); end
        // ADD r4 = r3 + r3 using the sticky carry
        model_exec(0, OP_ADD, 1, 0, 3, 3, 4, 1, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_ADD, 1, 0, 3, 3, 4, 1, 0, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (ci !== 1'b1) begin n_fail++; $display("FAIL flag_cin: got %b exp 1", ci); end
        n_checks++; if (res !== 9'h001 || Carry_flag !== 1'b0) begin n_fail++; $display("FAIL flag_add: res %h flag %b exp 001/0", res, Carry_flag); end
        // XOR r1^r2 with no write-back
        model_exec(0, OP_XOR, 0, 1, 1, 2, 6, 0, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_XOR, 0, 1, 1, 2, 6, 0, 0, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h0FE || nwr !== 0) begin n_fail++; $display("FAIL nowb_xor: res %h n %0d exp 0fe/0", res, nwr); end
        // ADD r2+r2, no write-back, still updates the flag
        model_exec(0, OP_ADD, 0, 0, 2, 2, 6, 0, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_ADD, 0, 0, 2, 2, 6, 0, 0, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h1E2 || nwr !== 0 || Carry_flag !== 1'b1) begin n_fail++; $display("FAIL nowb_flag: res %h n %0d flag %b exp 1e2/0/1", res, nwr, Carry_flag); end
    endtask

    task automatic test_stall();
        int lat, nwr, e_lat, e_nwr;
        logic [8:0] res, e_res;
        logic [2:0] wa;
        logic [7:0] wd;
        logic ci, e_ci;
        bit st;
        model_exec(0, OP_ADD, 0, 0, 1, 1, 5, 1, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_ADD, 0, 0, 1, 1, 5, 1, 0, 10, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b exp 1", st); end
        n_checks++; if (res !== 9'h01E || nwr !== 1 || wd !== 8'h1E) begin n_fail++; $display("FAIL stall_res: res %h n %0d d %h exp 01e/1/1e", res, nwr, wd); end
        n_checks++; if (In_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: in_ready %b exp 1", In_ready); end
    endtask

    task automatic test_back_to_back();
        int acc, w0, e_lat, e_nwr, guard;
        logic [8:0] e_res;
        logic e_ci;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge Clock);
            Res_ready = 1'b1;
            if (pass == 0) begin
                In_kind = 1; In_rd = 3'd7; In_imm = 8'h5A; In_wb = 0;
            end else begin
                In_kind = 0; In_opcode = OP_ADD; In_use_flag = 0; In_cin = 0;
                In_rs1 = 3'd1; In_rs2 = 3'd2; In_rd = 3'd6; In_wb = 0;
            end
            In_valid = 1'b1;
            w0 = wr_total;
            acc = 0;
            for (int i = 0; i < 15; i++) begin
                if (i > 0) @(negedge Clock);
                if (In_ready) begin
                    acc++;
                    model_exec(In_kind, In_opcode, In_use_flag, In_cin, In_rs1, In_rs2, In_rd,
                               In_wb, In_imm, e_res, e_lat, e_nwr, e_ci);
                end
            end
            In_valid = 1'b0;
            guard = 0;
            do begin @(posedge Clock); #1; guard++; end while (!In_ready && guard < 20);
            Res_ready = 1'b0;
            n_checks++; if (acc !== (pass == 0 ? 5 : 3)) begin n_fail++; $display("FAIL b2b_rate%0d: accepts %0d exp %0d", pass, acc, pass == 0 ? 5 : 3); end
            n_checks++; if ((wr_total - w0) !== (pass == 0 ? 5 : 0)) begin n_fail++; $display("FAIL b2b_writes%0d: got %0d", pass, wr_total - w0); end
            n_checks++; if (Carry_flag !== m_flag) begin n_fail++; $display("FAIL b2b_flag%0d: got %b exp %b", pass, Carry_flag, m_flag); end
        end
        n_checks++; if (wr_addr !== 3'd7 || wr_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_li_wr: a %0d d %h exp 7/5a", wr_addr, wr_data); end
    endtask

    task automatic test_reset_mid_wb();
        int lat, nwr, e_lat, e_nwr, guard;
        logic [8:0] res, e_res;
        logic [2:0] wa;
        logic [7:0] wd;
        logic ci, e_ci;
        bit st, seen;
        model_exec(1, 0, 0, 0, 0, 0, 5, 0, 8'hC8, e_res, e_lat, e_nwr, e_ci);
        do_instr(1, 0, 0, 0, 0, 0, 5, 0, 8'hC8, 0, lat, res, nwr, wa, wd, ci, st);
        // ADD r5 = r5 + r5 (carry out), reset while its write strobe is high
        @(negedge Clock);
        In_kind = 0; In_opcode = OP_ADD; In_use_flag = 0; In_cin = 0;
        In_rs1 = 3'd5; In_rs2 = 3'd5; In_rd = 3'd5; In_wb = 1;
        In_valid = 1'b1;
        @(posedge Clock);
        #1;
        In_valid = 1'b0;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 10) begin
            @(negedge Clock);
            guard++;
            if (Write_enable) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstwb_reach: write strobe seen %b exp 1", seen); end
        Reset_n = 1'b0;
        #1;
        n_checks++; if (Write_enable !== 1'b0 || In_ready !== 1'b1 || Res_valid !== 1'b0) begin n_fail++; $display("FAIL rstwb_state: we %b rdy %b vld %b exp 0/1/0", Write_enable, In_ready, Res_valid); end
        n_checks++; if (Carry_flag !== 1'b0) begin n_fail++; $display("FAIL rstwb_flag: got %b exp 0", Carry_flag); end
        m_flag = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        // Read r5 back through the ALU: OR r5|r5, no write-back
        model_exec(0, OP_OR, 0, 0, 5, 5, 0, 0, 0, e_res, e_lat, e_nwr, e_ci);
        do_instr(0, OP_OR, 0, 0, 5, 5, 0, 0, 0, 0, lat, res, nwr, wa, wd, ci, st);
        n_checks++; if (res !== 9'h0C8) begin n_fail++; $display("FAIL rstwb_readback: got %h exp 0c8", res); end
    endtask

    task automatic test_random();
        int lat, nwr, e_lat, e_nwr, stall;
        logic [8:0] res, e_res;
        logic [2:0] wa, rs1, rs2, rd, op;
        logic [7:0] wd, imm;
        logic ci, e_ci;
        bit st, kind, uf, cin, wb;
        for (int n = 0; n < 40; n++) begin
            kind = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 5)); uf = 1'($urandom); cin = 1'($urandom);
            rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
            wb = 1'($urandom); imm = 8'($urandom); stall = $urandom_range(0, 2);
            model_exec(kind, op, uf, cin, rs1, rs2, rd, wb, imm, e_res, e_lat, e_nwr, e_ci);
            do_instr(kind, op, uf, cin, rs1, rs2, rd, wb, imm, stall, lat, res, nwr, wa, wd, ci, st);
            n_checks++; if (res !== e_res || lat !== e_lat) begin n_fail++; $display("FAIL rand%0d_res: res %h lat %0d exp %h lat %0d", n, res, lat, e_res, e_lat); end
            n_checks++; if (nwr !== e_nwr || (e_nwr == 1 && (wa !== rd || wd !== e_res[7:0]))) begin n_fail++; $display("FAIL rand%0d_wr: n %0d a %0d d %h exp %0d/%0d/%h", n, nwr, wa, wd, e_nwr, rd, e_res[7:0]); end
            n_checks++; if (Carry_flag !== m_flag || (!kind && ci !== e_ci) || st !== 1'b1) begin n_fail++; $display("FAIL rand%0d_flag: flag %b cin %b stable %b exp %b/%b/1", n, Carry_flag, ci, st, m_flag, e_ci); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
